// File: rtl/dm_bridge_pkg.sv
// Shared types for the data-memory bus bridge: FSM state encoding and default sizing.
package dm_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEFAULT_XLEN    = 32;
   localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/dm_watchdog.sv
// Clearable saturating cycle counter; flags expiry on the TIMEOUT-th enabled cycle after a clear.
module dm_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = en && (count == LAST);

endmodule

// File: rtl/dm_bus_bridge.sv
// Turns the LSU's single-cycle data-memory access into a registered req/gnt/rvalid
// transaction, stalling the pipeline until it completes or the watchdog aborts it.
module dm_bus_bridge
   import dm_bridge_pkg::*;
#(
   parameter int XLEN    = DEFAULT_XLEN,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [XLEN-1:0] i_lsu_dm_addr,
   input  logic            i_lsu_dm_wvalid,
   input  logic [XLEN-1:0] i_lsu_dm_wdata,
   input  logic            i_lsu_dm_rvalid,
   output logic [XLEN-1:0] o_lsu_dm_rdata,
   output logic            o_stall,
   output logic            o_err,
   output logic            o_mem_req,
   output logic            o_mem_we,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   input  logic            i_mem_gnt,
   input  logic            i_mem_rvalid,
   input  logic [XLEN-1:0] i_mem_rdata,
   output state_t          o_dbg_state
);

   // Memory handshake: a request is accepted on any cycle where o_mem_req and
   // i_mem_gnt are both high; a write completes at acceptance, a read completes
   // on the first i_mem_rvalid seen after acceptance. Addr/wdata/we stay constant
   // from the first o_mem_req cycle until acceptance, and i_mem_rvalid is only
   // sampled while a read is waiting for its data.

   state_t          state;
   logic            lsu_req;
   logic            wd_clr;
   logic            wd_en;
   logic            wd_expired;
   logic [XLEN-1:0] rdata_q;

   assign lsu_req = i_lsu_dm_wvalid | i_lsu_dm_rvalid;
   assign wd_clr  = (state == IDLE) && lsu_req;
   assign wd_en   = (state == REQ) || (state == RESP);
   assign o_stall = wd_clr | wd_en;

   assign o_lsu_dm_rdata = rdata_q;
   assign o_dbg_state    = state;

   dm_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         o_err       <= 1'b0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         rdata_q     <= '0;
      end else begin
         o_err <= 1'b0;
         case (state)
            IDLE: begin
               if (lsu_req) begin
                  o_mem_addr  <= i_lsu_dm_addr;
                  o_mem_wdata <= i_lsu_dm_wdata;
                  o_mem_we    <= i_lsu_dm_wvalid;
                  o_mem_req   <= 1'b1;
                  o_err       <= i_lsu_dm_wvalid & i_lsu_dm_rvalid;
                  state       <= REQ;
               end
            end
            REQ: begin
               // A grant in the expiry cycle still completes the access.
               if (i_mem_gnt) begin
                  o_mem_req <= 1'b0;
                  state     <= o_mem_we ? DONE : RESP;
               end else if (wd_expired) begin
                  o_mem_req <= 1'b0;
                  o_err     <= 1'b1;
                  rdata_q   <= '0;
                  state     <= DONE;
               end
            end
            RESP: begin
               if (i_mem_rvalid) begin
                  rdata_q <= i_mem_rdata;
                  state   <= DONE;
               end else if (wd_expired) begin
                  o_err   <= 1'b1;
                  rdata_q <= '0;
                  state   <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
